// File: rtl/l1_cache_responder_pkg.sv
// Package cache_types: shared types and helpers for the L1 cache responder.
//
// Contents:
//   OFFSET_W        - byte-offset bits within a 32-byte line (fixed)
//   LINE_W          - line width in bits (256)
//   WORDS_PER_LINE  - 32-bit words per line (8)
//   rv32i_word      - 32-bit word
//   line_t          - one cache line as a packed array of 8 words
//   cache_state_t   - controller states
//   addr_tag / addr_index / addr_word - address field extraction helpers
package cache_types;

  localparam int OFFSET_W       = 5;
  localparam int LINE_W         = 256;
  localparam int WORDS_PER_LINE = 8;

  typedef logic [31:0] rv32i_word;
  typedef rv32i_word [WORDS_PER_LINE-1:0] line_t;

  typedef enum logic [1:0] {
    IDLE,
    WRITEBACK,
    FILL
  } cache_state_t;

  // The helpers return full 32-bit values because the field widths depend
  // on the set count; callers slice off the bits they need.
  function automatic rv32i_word addr_tag(rv32i_word addr, int s_index);
    return addr >> (OFFSET_W + s_index);
  endfunction

  function automatic rv32i_word addr_index(rv32i_word addr, int s_index);
    return (addr >> OFFSET_W) & ((32'd1 << s_index) - 32'd1);
  endfunction

  function automatic logic [2:0] addr_word(rv32i_word addr);
    return addr[4:2];
  endfunction

endpackage

// File: rtl/l1_cache_responder_array.sv
// l1_cache_array: storage for the direct-mapped cache.
//
// Holds valid, dirty, tag and data arrays. Valid and dirty are cleared
// asynchronously by rst_n; tag and data are left unreset. All reads are
// combinational from the set selected by index_i.
//
// Ports:
//   clk, rst_n      - clock / async active-low reset
//   index_i         - set being accessed (read and write)
//   word_i          - word within the line for CPU writes
//   write_en_i      - CPU write hit: merge wdata_i under byte_en_i, set dirty
//   wdata_i         - CPU write data
//   byte_en_i       - per-byte write enables
//   fill_en_i       - whole-line fill: load line and tag, valid=1, dirty=0
//   fill_tag_i      - tag stored on a fill
//   fill_line_i     - line data stored on a fill
//   clear_dirty_i   - writeback completed: clear dirty for the set
//   valid_o/dirty_o/tag_o/line_o - contents of the selected set
module l1_cache_array
  import cache_types::*;
#(
  parameter  int S_INDEX = 3,
  localparam int TAG_W   = 32 - OFFSET_W - S_INDEX
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [S_INDEX-1:0] index_i,
  input  logic [2:0]         word_i,
  input  logic               write_en_i,
  input  logic [31:0]        wdata_i,
  input  logic [3:0]         byte_en_i,
  input  logic               fill_en_i,
  input  logic [TAG_W-1:0]   fill_tag_i,
  input  logic [255:0]       fill_line_i,
  input  logic               clear_dirty_i,
  output logic               valid_o,
  output logic               dirty_o,
  output logic [TAG_W-1:0]   tag_o,
  output logic [255:0]       line_o
);

  localparam int SETS = 1 << S_INDEX;

  logic [SETS-1:0] valid_q;
  logic [SETS-1:0] dirty_q;
  logic [TAG_W-1:0] tag_q [SETS];
  line_t            data_q [SETS];

  // A write with no byte lanes enabled still marks the line dirty.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= '0;
      dirty_q <= '0;
    end else begin
      if (fill_en_i) begin
        valid_q[index_i] <= 1'b1;
        dirty_q[index_i] <= 1'b0;
      end else if (write_en_i) begin
        dirty_q[index_i] <= 1'b1;
      end else if (clear_dirty_i) begin
        dirty_q[index_i] <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (fill_en_i) begin
      tag_q[index_i]  <= fill_tag_i;
      data_q[index_i] <= fill_line_i;
    end else if (write_en_i) begin
      for (int b = 0; b < 4; b++) begin
        if (byte_en_i[b]) begin
          data_q[index_i][word_i][8*b +: 8] <= wdata_i[8*b +: 8];
        end
      end
    end
  end

  assign valid_o = valid_q[index_i];
  assign dirty_o = dirty_q[index_i];
  assign tag_o   = tag_q[index_i];
  assign line_o  = data_q[index_i];

endmodule

// File: rtl/l1_cache_responder.sv
// l1_cache_responder: direct-mapped, write-back, write-allocate L1 cache
// serving one pipeline port (instruction or data).
//
// Hits complete combinationally in the request cycle. A miss writes back a
// dirty victim (WRITEBACK), fetches the line (FILL), then returns to IDLE
// where the held request hits.
//
// Ports:
//   clk, rst_n                     - clock / async active-low reset
//   mem_read, mem_write            - CPU request, held until mem_resp
//   mem_address, mem_wdata         - CPU byte address / write data
//   mem_byte_enable                - write byte lanes
//   mem_rdata, mem_resp            - read data / one-cycle completion
//   pmem_read, pmem_write          - line fill / writeback request
//   pmem_address                   - line-aligned memory address
//   pmem_wdata                     - victim line for writeback
//   pmem_rdata, pmem_resp          - fill data / memory completion
//   hit_count, miss_count          - only with L1_CACHE_STATS_EN defined
//
// Optional feature macro: L1_CACHE_STATS_EN adds saturating hit and miss
// counters. When undefined the ports and logic are absent.
module l1_cache_responder
  import cache_types::*;
#(
  parameter int S_INDEX = 3
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         mem_read,
  input  logic         mem_write,
  input  logic [31:0]  mem_address,
  input  logic [31:0]  mem_wdata,
  input  logic [3:0]   mem_byte_enable,
  output logic [31:0]  mem_rdata,
  output logic         mem_resp,
  output logic         pmem_read,
  output logic         pmem_write,
  output logic [31:0]  pmem_address,
  output logic [255:0] pmem_wdata,
  input  logic [255:0] pmem_rdata,
`ifdef L1_CACHE_STATS_EN
  output logic [31:0]  hit_count,
  output logic [31:0]  miss_count,
`endif
  input  logic         pmem_resp
);

  localparam int TAG_W = 32 - OFFSET_W - S_INDEX;

  cache_state_t state_q, state_d;

  rv32i_word          tag_full, index_full;
  logic [TAG_W-1:0]   tag;
  logic [S_INDEX-1:0] index;
  logic [2:0]         word;

  logic               arr_valid, arr_dirty;
  logic [TAG_W-1:0]   arr_tag;
  logic [255:0]       arr_line;
  line_t              cur_line;
  logic               hit;

  logic               write_hit, fill_en, clear_dirty;

  assign tag_full   = addr_tag(mem_address, S_INDEX);
  assign index_full = addr_index(mem_address, S_INDEX);
  assign tag        = tag_full[TAG_W-1:0];
  assign index      = index_full[S_INDEX-1:0];
  assign word       = addr_word(mem_address);

  // Upper bits of the helper results are always zero by construction.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{tag_full[31:TAG_W], index_full[31:S_INDEX]};

  l1_cache_array #(
    .S_INDEX (S_INDEX)
  ) u_array (
    .clk           (clk),
    .rst_n         (rst_n),
    .index_i       (index),
    .word_i        (word),
    .write_en_i    (write_hit),
    .wdata_i       (mem_wdata),
    .byte_en_i     (mem_byte_enable),
    .fill_en_i     (fill_en),
    .fill_tag_i    (tag),
    .fill_line_i   (pmem_rdata),
    .clear_dirty_i (clear_dirty),
    .valid_o       (arr_valid),
    .dirty_o       (arr_dirty),
    .tag_o         (arr_tag),
    .line_o        (arr_line)
  );

  assign cur_line   = arr_line;
  assign hit        = arr_valid && (arr_tag == tag);
  assign pmem_wdata = arr_line;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // pmem_* are decoded from the state register alone, so an async reset
  // drops them immediately and a late pmem_resp lands in IDLE, where it
  // has no effect.
  always_comb begin
    state_d      = state_q;
    mem_resp     = 1'b0;
    mem_rdata    = '0;
    pmem_read    = 1'b0;
    pmem_write   = 1'b0;
    pmem_address = '0;
    write_hit    = 1'b0;
    fill_en      = 1'b0;
    clear_dirty  = 1'b0;
    case (state_q)
      IDLE: begin
        if (mem_read || mem_write) begin
          if (hit) begin
            mem_resp  = 1'b1;
            write_hit = mem_write;
            if (mem_read) begin
              mem_rdata = cur_line[word];
            end
          end else if (arr_valid && arr_dirty) begin
            state_d = WRITEBACK;
          end else begin
            state_d = FILL;
          end
        end
      end
      WRITEBACK: begin
        pmem_write   = 1'b1;
        pmem_address = {arr_tag, index, {OFFSET_W{1'b0}}};
        if (pmem_resp) begin
          clear_dirty = 1'b1;
          state_d     = FILL;
        end
      end
      FILL: begin
        pmem_read    = 1'b1;
        pmem_address = {tag, index, {OFFSET_W{1'b0}}};
        if (pmem_resp) begin
          fill_en = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

`ifdef L1_CACHE_STATS_EN
  logic        fill_done_q;
  logic [31:0] hit_count_q, miss_count_q;

  // fill_done_q marks the IDLE cycle right after a fill, whose hit is the
  // completion of the miss and must not be counted as a hit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fill_done_q  <= 1'b0;
      hit_count_q  <= '0;
      miss_count_q <= '0;
    end else begin
      fill_done_q <= fill_en;
      if (mem_resp && !fill_done_q && (hit_count_q != 32'hFFFF_FFFF)) begin
        hit_count_q <= hit_count_q + 32'd1;
      end
      if ((state_q == IDLE) && (state_d != IDLE) &&
          (miss_count_q != 32'hFFFF_FFFF)) begin
        miss_count_q <= miss_count_q + 32'd1;
      end
    end
  end

  assign hit_count  = hit_count_q;
  assign miss_count = miss_count_q;
`endif

endmodule
